// File: rtl/ram_port_arbiter.sv
// Arbitrates the shared single-port RAM between the CPU core and the host loader/debug port.
// The CPU has priority, with a starvation override and a host exclusive-lock mode.
module ram_port_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rden,
  input  logic          cpu_wren,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          host_locked,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic {SHARE, LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state, state_nxt;
  owner_t        rd_owner, rd_owner_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic [DW-1:0] cpu_rdata_q, host_rdata_q;
  logic          cpu_gnt;
  logic          cpu_acc;

  assign cpu_acc = cpu_rden | cpu_wren;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SHARE;
      wait_cnt     <= '0;
      rd_owner     <= OWN_NONE;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      rd_owner     <= rd_owner_nxt;
      cpu_rdata_q  <= cpu_rdata;
      host_rdata_q <= host_rdata;
    end
  end

  // Reset gates every output combinationally so a read in flight at the reset edge never surfaces.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    rd_owner_nxt = OWN_NONE;
    cpu_gnt      = 1'b0;
    host_gnt     = 1'b0;
    cpu_hold     = 1'b0;
    host_locked  = 1'b0;
    ram_addr     = '0;
    ram_data_in  = '0;
    ram_rden     = 1'b0;
    ram_wren     = 1'b0;
    cpu_rdata    = '0;
    host_rdata   = '0;
    host_rvalid  = 1'b0;
    if (!rst) begin
      unique case (state)
        SHARE: begin
          if (host_req && wait_cnt == LIMIT) begin
            host_gnt = 1'b1;
            cpu_hold = 1'b1;
          end else if (cpu_acc) begin
            cpu_gnt = 1'b1;
            if (host_req) wait_cnt_nxt = wait_cnt + 4'd1;
          end else if (host_req) begin
            host_gnt = 1'b1;
          end
          if (host_lock) state_nxt = LOCKED;
        end
        LOCKED: begin
          cpu_hold    = 1'b1;
          host_locked = 1'b1;
          host_gnt    = host_req;
          if (!host_lock && !host_req) state_nxt = SHARE;
        end
      endcase

      if (host_gnt) begin
        ram_addr    = host_addr;
        ram_data_in = host_wdata;
        ram_wren    = host_we;
        ram_rden    = !host_we;
        if (!host_we) rd_owner_nxt = OWN_HOST;
      end else if (cpu_gnt) begin
        ram_addr    = cpu_addr;
        ram_data_in = cpu_wdata;
        ram_wren    = cpu_wren;
        ram_rden    = !cpu_wren;
        if (!cpu_wren) rd_owner_nxt = OWN_CPU;
      end

      cpu_rdata   = (rd_owner == OWN_CPU)  ? ram_data_out : cpu_rdata_q;
      host_rdata  = (rd_owner == OWN_HOST) ? ram_data_out : host_rdata_q;
      host_rvalid = (rd_owner == OWN_HOST);
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port program/data RAM between the CPU core and a host loader/debug port. The CPU has priority, but a starvation counter forces a one-cycle CPU hold when the host has waited too long. A lock mode gives the host exclusive RAM ownership for program download. Read data is steered back to whichever requester issued the read one cycle earlier. The block sits between `cpu` (pc/stage/opcode path) and `ram`.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `STARVE_LIMIT`, 4, consecutive denied host-request cycles before a forced host grant (1..15)

Ports:
- `clk` in 1: system clock; all state updates on rising edge
- `rst` in 1: reset; synchronous, active-high
- `cpu_rden` in 1: CPU read request this cycle
- `cpu_wren` in 1: CPU write request this cycle
- `cpu_addr` in AW: CPU address
- `cpu_wdata` in DW: CPU write data
- `cpu_rdata` out DW: CPU read data (registered hold)
- `cpu_hold` out 1: CPU must freeze its stage/pc and repeat its request
- `host_req` in 1: host access request, held until granted
- `host_we` in 1: 1 = write, 0 = read
- `host_lock` in 1: request exclusive ownership
- `host_addr` in AW: host address
- `host_wdata` in DW: host write data
- `host_gnt` out 1: host access performed this cycle
- `host_rvalid` out 1: `host_rdata` valid (one-cycle pulse)
- `host_rdata` out DW: host read data
- `host_locked` out 1: lock state active
- `ram_addr` out AW, `ram_data_in` out DW, `ram_rden` out 1, `ram_wren` out 1: RAM port
- `ram_data_out` in DW: RAM read data; valid the cycle after `ram_rden`

## Operation
- The FSM has two states:
  - SHARE (reset state)
  - LOCKED
- SHARE, per-cycle grant (combinational from the current inputs and registered state):
  - CPU access = `cpu_rden | cpu_wren`. If both are high, it is a write.
  - Forced cycle when `host_req` and `wait_cnt == STARVE_LIMIT`: host granted, `cpu_hold`=1, CPU request not forwarded, `wait_cnt` cleared.
  - Otherwise, if there is a CPU access: CPU granted. If `host_req`, `wait_cnt` increments.
  - Otherwise, if `host_req`: host granted, `wait_cnt` cleared.
  - Otherwise: RAM idle (`ram_rden`=`ram_wren`=0).
  - When `host_req`=0, `wait_cnt` is held at 0.
- The granted requester drives `ram_addr`, `ram_data_in` and either `ram_rden` or `ram_wren`.
- SHARE→LOCKED: on the edge where `host_lock`=1 is sampled.
- LOCKED:
  - `cpu_hold`=1 every cycle; `host_locked`=1.
  - The host is granted every cycle that `host_req`=1; CPU requests are ignored.
- LOCKED→SHARE: on the edge where `host_lock`=0 and `host_req`=0 are sampled.
- Read return:
  - The registered `rd_owner` (NONE/CPU/HOST) records the owner of the read issued in the current cycle.
  - Next cycle, if the owner was HOST: `host_rdata` ← `ram_data_out` and `host_rvalid`=1.
  - Next cycle, if the owner was CPU: `cpu_rdata` ← `ram_data_out`.
  - `cpu_rdata` holds its value otherwise.
- Writes return nothing; `host_rvalid` stays 0 for host writes.

## Timing
- Grant, `cpu_hold` and the RAM control outputs are combinational in the request cycle (zero-cycle arbitration).
- Read latency is 1 cycle: `host_rvalid` is asserted at N+1 for a host read granted at N.
- Lock entry: `cpu_hold` rises the cycle after `host_lock` is first sampled high. A host request in the sampling cycle still arbitrates under SHARE rules.
- Worst-case host wait in SHARE is `STARVE_LIMIT` cycles; the grant comes on cycle `STARVE_LIMIT`+1 after the request.
- Simultaneous events:
  - Forced cycle plus a CPU write: the write is dropped this cycle and the CPU must retry it (hold contract).
  - `host_lock` deasserted while `host_req`=1: stay in LOCKED until `host_req`=0.
- Reset (synchronous, takes precedence over everything, including mid-lock or mid-read):
  - state=SHARE, `wait_cnt`=0, `rd_owner`=NONE.
  - All outputs 0: `cpu_rdata`, `host_rdata`, `ram_*`, `cpu_hold`, `host_gnt`, `host_rvalid`, `host_locked`.
  - A read pending at the reset edge produces no `host_rvalid`.

## Test plan
- CPU-only traffic: `cpu_rden`=1 with `cpu_addr`=0x10 and RAM[0x10]=0xA5 → `ram_rden`=1 and `ram_addr`=0x10 the same cycle; `cpu_rdata`=0xA5 next cycle; `cpu_hold` stays 0.
- Host in CPU idle gap: CPU idle; host read of 0x20 (RAM=0x3C) → `host_gnt`=1 that cycle; next cycle `host_rvalid`=1 and `host_rdata`=0x3C.
- Starvation with `STARVE_LIMIT`=4: CPU reads every cycle and `host_req` is held → host denied for 4 cycles. On the 5th cycle `host_gnt`=1 and `cpu_hold`=1, the CPU address is not on `ram_addr`, and `wait_cnt` returns to 0.
- Lock download:
  - Assert `host_lock` and write 0x50→0x00, 0x0A→0x01, 0xFF→0x02 on consecutive cycles while the CPU requests reads.
  - Required: `cpu_hold`=1 throughout, RAM contents match, and there are no CPU grants.
  - Release lock and drop `host_req` → SHARE next cycle and `cpu_hold`=0.
- Simultaneous `cpu_rden`+`cpu_wren` to 0x30 with data 0x77 → `ram_wren`=1, `ram_rden`=0, and RAM[0x30]=0x77.
- Reset mid-operation:
  - Assert `rst` in LOCKED, in the cycle after a host read grant → no `host_rvalid`.
  - All outputs are 0 the next cycle, with the state in SHARE.
